// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel counters, syncs, data-enable and strobes.
// Optional macro VGA_SYNC_ALIGN_EN delays hsync/vsync/de by one pixel.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CLK_DIV   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       pix_tick,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0]    H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0]    V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0]    HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]    HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]    VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]    VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d;

  // Gated by rst so the strobe is quiet while reset holds the prescaler at zero.
  assign pix_tick = en && !rst && (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q;
    if (en) presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
  end

  always_comb begin
    h_d = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
  end

  // Decode the position the counters move to, so outputs line up with it.
  always_comb begin
    hs_d = ((h_d >= HS_FIRST) && (h_d <= HS_LAST)) ? HSYNC_POL : ~HSYNC_POL;
    vs_d = ((v_d >= VS_FIRST) && (v_d <= VS_LAST)) ? VSYNC_POL : ~VSYNC_POL;
    de_d = (h_d < H_ACT) && (v_d < V_ACT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      h_q     <= '0;
      v_q     <= '0;
      hs_q    <= ~HSYNC_POL;
      vs_q    <= ~VSYNC_POL;
      de_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      if (pix_tick) begin
        h_q  <= h_d;
        v_q  <= v_d;
        hs_q <= hs_d;
        vs_q <= vs_d;
        de_q <= de_d;
      end
    end
  end

`ifdef VGA_SYNC_ALIGN_EN
  logic hs2_q, vs2_q, de2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs2_q <= ~HSYNC_POL;
      vs2_q <= ~VSYNC_POL;
      de2_q <= 1'b0;
    end else if (pix_tick) begin
      hs2_q <= hs_q;
      vs2_q <= vs_q;
      de2_q <= de_q;
    end
  end

  assign hsync = hs2_q;
  assign vsync = vs2_q;
  assign de    = de2_q;
`else
  assign hsync = hs_q;
  assign vsync = vs_q;
  assign de    = de_q;
`endif

  assign hcount      = h_q;
  assign vcount      = v_q;
  assign line_start  = pix_tick && (h_q == 10'd0);
  assign frame_start = line_start && (v_q == 10'd0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations share en/rst; a pixel-count
// reference model feeds an expected queue that a negedge monitor drains.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;

`ifdef VGA_SYNC_ALIGN_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif

  int checks   = 0;
  int failures = 0;

  logic [77:0] exp_q[$];

  int p_a = 0, n_a = 0, p_b = 0, n_b = 0, p_c = 0, n_c = 0;

  logic [9:0] hc_a, vc_a, hc_b, vc_b, hc_c, vc_c;
  logic hs_a, vs_a, de_a, pt_a, ls_a, fs_a;
  logic hs_b, vs_b, de_b, pt_b, ls_b, fs_b;
  logic hs_c, vs_c, de_c, pt_c, ls_c, fs_c;

  // A: tiny raster, CLK_DIV=1, active-low syncs
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(1)
  ) u_a (
    .clk(clk), .rst(rst), .en(en), .hcount(hc_a), .vcount(vc_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .pix_tick(pt_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  // B: tiny raster, CLK_DIV=2, active-high syncs
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(2)
  ) u_b (
    .clk(clk), .rst(rst), .en(en), .hcount(hc_b), .vcount(vc_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .pix_tick(pt_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  // C: default 640x480 timing
  vga_timing_gen u_c (
    .clk(clk), .rst(rst), .en(en), .hcount(hc_c), .vcount(vc_c),
    .hsync(hs_c), .vsync(vs_c), .de(de_c), .pix_tick(pt_c),
    .line_start(ls_c), .frame_start(fs_c)
  );

  // p = pixel ticks since reset, n = enabled clocks since reset.
  function automatic logic [25:0] ref_out(
    input int p, input int n, input logic en_v, input logic rst_v,
    input int ha, input int hfp, input int hsw, input int hbp,
    input int va, input int vfp, input int vsw, input int vbp,
    input bit hpol, input bit vpol, input int div);
    int ht, vt, h, v, qh, qv;
    logic tick, valid, hs, vs, de_e, ls;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    if (rst_v) return {10'd0, 10'd0, ~hpol, ~vpol, 1'b0, 1'b0, 1'b0, 1'b0};
    h     = p % ht;
    v     = (p / ht) % vt;
    tick  = en_v && ((n % div) == div - 1);
    valid = (p >= 1 + LAG);
    qh    = (p - LAG) % ht;
    qv    = ((p - LAG) / ht) % vt;
    hs    = ~hpol;
    vs    = ~vpol;
    de_e  = 1'b0;
    if (valid) begin
      if (qh >= ha + hfp && qh < ha + hfp + hsw) hs = hpol;
      if (qv >= va + vfp && qv < va + vfp + vsw) vs = vpol;
      de_e = (qh < ha) && (qv < va);
    end
    ls = tick && (h == 0);
    return {10'(h), 10'(v), hs, vs, de_e, tick, ls, ls && (v == 0)};
  endfunction

  task automatic step(input logic en_v, input logic rst_v);
    logic [25:0] ea, eb, ec;
    @(posedge clk);
    #2;
    rst = rst_v;
    en  = en_v;
    if (rst_v) begin
      p_a = 0; n_a = 0; p_b = 0; n_b = 0; p_c = 0; n_c = 0;
    end
    ea = ref_out(p_a, n_a, en_v, rst_v, 8, 2, 3, 2, 5, 1, 2, 1, 1'b0, 1'b0, 1);
    eb = ref_out(p_b, n_b, en_v, rst_v, 8, 2, 3, 2, 5, 1, 2, 1, 1'b1, 1'b1, 2);
    ec = ref_out(p_c, n_c, en_v, rst_v, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 1);
    exp_q.push_back({ec, eb, ea});
    if (!rst_v) begin
      if (ea[2]) p_a++;
      if (eb[2]) p_b++;
      if (ec[2]) p_c++;
      if (en_v) begin
        n_a++; n_b++; n_c++;
      end
    end
  endtask

  task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s t=%0t got h=%0d v=%0d hs/vs/de/tick/ls/fs=%b want h=%0d v=%0d hs/vs/de/tick/ls/fs=%b",
               name, $time, act[25:16], act[15:6], act[5:0], exp_v[25:16], exp_v[15:6], exp_v[5:0]);
    end
  endtask

  always @(negedge clk) begin
    logic [77:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("cfg_a", {hc_a, vc_a, hs_a, vs_a, de_a, pt_a, ls_a, fs_a}, e[25:0]);
      check("cfg_b", {hc_b, vc_b, hs_b, vs_b, de_b, pt_b, ls_b, fs_b}, e[51:26]);
      check("cfg_c", {hc_c, vc_c, hs_c, vs_c, de_c, pt_c, ls_c, fs_c}, e[77:52]);
    end
  end

  initial begin
    repeat (3) step(1'b0, 1'b1);
    // Mostly-enabled run with sparse en drops and one 10-clock hold.
    for (int i = 0; i < 18000; i++) begin
      if (i == 5000) repeat (10) step(1'b0, 1'b0);
      step(($urandom_range(0, 15) != 0), 1'b0);
    end
    // Reset lands between edges, mid-frame, with arbitrary en.
    repeat (2) step(1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 12000; i++) step(1'($urandom_range(0, 1)), 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got %0d entries left want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
